// File: rtl/xup_tff_sched_pkg.sv
// Shared types and helpers for the XUP tff toggle scheduler and related arbiters.
package xup_tff_sched_pkg;

    // Scheduler state encoding (IDLE=0, ISSUE=1, SETTLE=2). The ST_ prefix keeps
    // the literals clear of the SETTLE parameter in modules importing this package.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2
    } sched_state_e;

    // Ceiling log2 for sizing index fields at elaboration time.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/xup_rr_pick.sv
// Combinational round-robin picker: the first valid requester at or after
// rr_ptr (wrapping modulo NREQ) wins. Reusable by other XUP arbiters.
module xup_rr_pick
    import xup_tff_sched_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [IDW-1:0]  winner,
    output logic            any_valid
);

    // Scan offsets from far to near so the requester closest to rr_ptr is written last and wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        winner    = '0;
        any_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                winner    = IDW'((int'(rr_ptr) + k) % NREQ);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xup_tff_toggle_scheduler.sv
// Round-robin scheduler sharing one xup_tff_vector among NREQ requesters.
// One granted mask is driven on t for a single cycle, followed by SETTLE
// cycles of t=0 before the next grant can be accepted.
// Optional feature macro: XUP_TFF_SCHED_SHADOW_EN adds q_shadow/shadow_clear,
// a zero-latency mirror of the downstream tff vector state.
module xup_tff_toggle_scheduler
    import xup_tff_sched_pkg::*;
#(
    parameter  int SIZE   = 8,
    parameter  int NREQ   = 4,
    parameter  int SETTLE = 2,
    localparam int IDW    = clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*SIZE-1:0] req_mask,
    output logic [NREQ-1:0]      req_ready,
    output logic [SIZE-1:0]      t,
    output logic                 grant_valid,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy
`ifdef XUP_TFF_SCHED_SHADOW_EN
    ,
    input  logic                 shadow_clear,
    output logic [SIZE-1:0]      q_shadow
`endif
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE);

    sched_state_e   state;
    logic [IDW-1:0] rr_ptr;
    logic [3:0]     settle_cnt;
    logic [IDW-1:0] winner;
    logic           any_valid;
    logic           accept;
    logic [IDW-1:0] rr_next;

    xup_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // A request is taken only from IDLE, and never while reset is applied.
    assign accept  = (state == ST_IDLE) && any_valid && !reset;
    assign rr_next = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
    assign busy    = (state != ST_IDLE);

    // One-hot ready toward the single winner of this IDLE cycle.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Grant FSM: latch the winner's mask into t for one cycle, then hold t at zero for the settle window.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge (synchronous), and all state uses non-blocking assignments.
        if (reset) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            settle_cnt  <= '0;
            t           <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        t           <= req_mask[int'(winner) * SIZE +: SIZE];
                        grant_valid <= 1'b1;
                        grant_id    <= winner;
                        rr_ptr      <= rr_next;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    t           <= '0;
                    grant_valid <= 1'b0;
                    settle_cnt  <= SETTLE_LOAD;
                    state       <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt == 4'd1) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    t           <= '0;
                    grant_valid <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef XUP_TFF_SCHED_SHADOW_EN
    // Track the tff vector's q by applying the same toggles it receives.
    always_ff @(posedge clk) begin
        if (reset || shadow_clear) begin
            q_shadow <= '0;
        end else begin
            q_shadow <= q_shadow ^ t;
        end
    end
`endif

endmodule

// File: doc/xup_tff_toggle_scheduler.md
Name: xup_tff_toggle_scheduler

Overview:
- Round-robin scheduler that shares one xup_tff_vector instance among NREQ requesters.
- Each requester presents a SIZE-bit toggle mask with a valid/ready handshake.
- The scheduler drives the tff vector's t input with exactly one granted mask for one cycle, then holds t at zero for a programmable settle window before the next grant.
- Sits between requester logic and the tff vector. Its t output connects directly to the tff vector's t; clk is shared.

Parameters:
- SIZE, 8, width of each toggle mask and of t.
- NREQ, 4, number of requesters (2..16).
- SETTLE, 2, cycles t is held at zero after each issue (1..15).
- IDW, $clog2(NREQ), width of grant_id (localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock shared with the tff vector.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester mask valid.
- req_mask  input  NREQ*SIZE  flattened masks; requester i occupies bits [i*SIZE +: SIZE].
- req_ready  output  NREQ  one-hot; high in the cycle requester i's mask is accepted.
- t  output  SIZE  registered toggle vector to the tff vector.
- grant_valid  output  1  registered; high in the cycle t carries a granted mask.
- grant_id  output  IDW  registered; index of the requester whose mask is on t.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset values: t=0, grant_valid=0, grant_id=0, req_ready=0, busy=0, state=IDLE, rr_ptr=0, settle_cnt=0.
- Reset applies on any clk edge with reset=1, including mid-ISSUE or mid-SETTLE. t returns to 0 on the next edge and pending requests are not accepted.
- States:
  - IDLE: if any req_valid, select the winner, assert req_ready[winner] combinationally, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: one cycle; t=req_mask of winner (registered at the accept edge), grant_valid=1, grant_id=winner, settle_cnt loaded with SETTLE. Go to SETTLE.
  - SETTLE: t=0, grant_valid=0, settle_cnt decrements each cycle. When settle_cnt reaches 1, go to IDLE.
- Latency: accept edge to t valid = 1 cycle. Minimum spacing between successive non-zero t cycles = SETTLE+2 (IDLE cycle included).
- Arbitration:
  - Search begins at rr_ptr and wraps modulo NREQ. The first valid requester wins.
  - After a grant, rr_ptr = winner+1, wrapping NREQ-1 -> 0.
- Handshake:
  - req_ready is asserted only in IDLE, to at most one requester.
  - A requester must hold req_valid and req_mask stable until ready.
  - req_valid dropping before ready is legal; that request is simply not served.
  - A mask of all zeros is accepted and issued normally, producing a t=0 grant cycle with grant_valid=1.
- t is never non-zero outside ISSUE. This guarantees the tff vector toggles at most once per grant.
- Simultaneous requests: exactly one is served per IDLE visit; the others wait, and no request is lost or merged.

Optional Feature:
- Macro: XUP_TFF_SCHED_SHADOW_EN.
- Defined: adds output q_shadow [SIZE-1:0], reset to 0.
  - Updated q_shadow <= q_shadow ^ t every cycle, so it mirrors the tff vector's q (which powers up at 0) without the tff's output delay.
  - Also adds input shadow_clear, which zeroes q_shadow synchronously. shadow_clear is for a reset-synchronised tff only; otherwise do not use it.
- Undefined: no q_shadow port and no shadow register; all other behaviour identical.

Decomposition:
- Package xup_tff_sched_pkg holds:
  - state encoding constants IDLE=2'd0, ISSUE=2'd1, SETTLE=2'd2;
  - a clog2 helper function.
- One sub-module, xup_rr_pick: combinational round-robin picker (req_valid, rr_ptr -> winner, any_valid). It is reusable by other XUP arbiters.

Test Plan:
- Reset: assert reset 3 cycles with all req_valid=1 -> t=0, req_ready=0, busy=0 throughout; the first grant goes to requester 0 one cycle after reset deasserts.
- Single request: req 2 valid, mask 8'hA5 -> ready[2] one cycle, then t=8'hA5 and grant_id=2 for exactly 1 cycle, then t=0 for 2 cycles; tff q ends at 8'hA5.
- Fairness: all 4 valid continuously with masks 01/02/04/08 -> grant order 0,1,2,3,0; non-zero t every 4 cycles.
- Wrap: rr_ptr=3, req 1 and 3 valid -> 3 granted first, then 1.
- Reset mid-SETTLE: reset during SETTLE cycle 1 -> next cycle state=IDLE, t=0, rr_ptr=0.
- SHADOW_EN: two grants of 8'hFF and 8'h0F -> q_shadow=8'hF0 and equals tff q after DELAY.
